// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; grant registered, ack/wr_en/data combinational.
// Full stalls the owner without releasing it; each grant is capped at MAX_BURST accepted words.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATASIZE  = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*DATASIZE-1:0] req_data_i,
  output logic [NREQ-1:0]          ack_o,
  output logic [NREQ-1:0]          grant_o,
  input  logic                     full_i,
  output logic                     wr_en_o,
  output logic [DATASIZE-1:0]      data_in_o
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       burst_cnt_q, burst_cnt_d;

  logic [PW-1:0]       gidx;
  logic [PW-1:0]       nxt_ptr;
  logic [CW-1:0]       cnt_inc;
  logic                rel;
  logic [DATASIZE-1:0] lane [NREQ];

  // First requester at or after base, scanning modulo NREQ.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [PW-1:0]   base);
    logic [NREQ-1:0] g;
    logic            found;
    logic [PW-1:0]   idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(base) + k) % NREQ);
      if (!found && r[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) lane[i] = req_data_i[i*DATASIZE +: DATASIZE];
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) gidx = PW'(i);
    end
  end

  assign ack_o     = grant_q & req_i & {NREQ{~full_i & ~rst_i}};
  assign wr_en_o   = |ack_o;
  assign data_in_o = (state_q == BUSY && !rst_i) ? lane[gidx] : '0;
  assign grant_o   = grant_q;

  assign nxt_ptr = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
  assign cnt_inc = burst_cnt_q + CW'(wr_en_o);
  // A blocked word (full) never completes the burst, so full cannot cause a release.
  assign rel     = !req_i[gidx] || (wr_en_o && cnt_inc == CW'(MAX_BURST));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          grant_d     = rr_pick(req_i, ptr_q);
          burst_cnt_d = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        burst_cnt_d = cnt_inc;
        if (rel) begin
          ptr_d       = nxt_ptr;
          grant_d     = rr_pick(req_i, nxt_ptr);
          burst_cnt_d = '0;
          state_d     = (|req_i) ? BUSY : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences, FIFO end-to-end and random vs model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, full, wr_en;
  logic [N-1:0] req, ack, grant;
  logic [N*W-1:0] req_data;
  logic [W-1:0] data_in;

  logic         rst1, full1, wr_en1;
  logic [N-1:0] req1, ack1, grant1;
  logic [N*W-1:0] req_data1;
  logic [W-1:0] data_in1;

  fifo_wr_arbiter #(.NREQ(N), .DATASIZE(W), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_data_i(req_data), .ack_o(ack),
    .grant_o(grant), .full_i(full), .wr_en_o(wr_en), .data_in_o(data_in));

  fifo_wr_arbiter #(.NREQ(N), .DATASIZE(W), .MAX_BURST(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .req_i(req1), .req_data_i(req_data1), .ack_o(ack1),
    .grant_o(grant1), .full_i(full1), .wr_en_o(wr_en1), .data_in_o(data_in1));

  int tests = 0;
  int fails = 0;

  logic [W-1:0] pq [N][$];
  logic [W-1:0] fq [$];

  int m_own = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  logic [N-1:0] c_ack, c_grant;
  logic         c_wr;
  logic [W-1:0] c_data;

  typedef struct {
    logic         rst;
    logic         full;
    logic [N-1:0] req;
    logic [N-1:0] g;
    logic [N-1:0] a;
  } vec_t;
  vec_t tbl [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int base);
    for (int k = 0; k < N; k++) begin
      if (r[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic model_out(output logic [N-1:0] eg, output logic [N-1:0] ea,
                           output logic ew, output logic [W-1:0] ed);
    eg = '0; ea = '0; ew = 1'b0; ed = '0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    if (!rst && m_own >= 0) begin
      ed = req_data[m_own*W +: W];
      if (req[m_own] && !full) begin
        ea[m_own] = 1'b1;
        ew = 1'b1;
      end
    end
  endtask

  task automatic model_edge();
    int c;
    if (rst) begin
      m_own = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_own < 0) begin
      m_own = pick(req, m_ptr); m_cnt = 0;
    end else begin
      c = m_cnt + ((req[m_own] && !full) ? 1 : 0);
      if (!req[m_own] || c == MB) begin
        m_ptr = (m_own + 1) % N;
        m_own = pick(req, m_ptr);
        m_cnt = 0;
      end else begin
        m_cnt = c;
      end
    end
  endtask

  // One clock: present queue heads, compare against the model, consume acked words.
  task automatic cycle(input logic rst_v, input logic full_v);
    logic [N-1:0] eg, ea;
    logic         ew;
    logic [W-1:0] ed;
    rst  = rst_v;
    full = full_v;
    for (int i = 0; i < N; i++) begin
      req[i] = (pq[i].size() > 0);
      req_data[i*W +: W] = (pq[i].size() > 0) ? pq[i][0] : '0;
    end
    #2;
    model_out(eg, ea, ew, ed);
    check("model", {grant, ack, wr_en, data_in}, {eg, ea, ew, ed});
    c_ack = ack; c_grant = grant; c_wr = wr_en; c_data = data_in;
    @(posedge clk);
    model_edge();
    for (int i = 0; i < N; i++) begin
      if (c_ack[i]) void'(pq[i].pop_front());
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() == 0) break;
      cycle(1'b0, 1'b0);
    end
    check("drain_empty", 64'(pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size()), 64'd0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] exp_d, d;
    int e, got, id, seq;
    int nxt [3];
    bit saw_stall;

    rst = 1'b1; full = 1'b0; req = '0; req_data = '0;
    rst1 = 1'b1; full1 = 1'b0; req1 = '1; req_data1 = {4'h4, 4'h3, 4'h2, 4'h1};
    repeat (2) @(negedge clk);
    check("reset_grant", grant, '0);
    check("reset_ptr", dut.ptr_q, '0);

    // Vector table: one row per cycle, expected grant and ack during that cycle.
    tbl[0]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100};
    tbl[4]  = '{1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0000};
    tbl[5]  = '{1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100};
    tbl[6]  = '{1'b0, 1'b0, 4'b0000, 4'b0100, 4'b0000};
    tbl[7]  = '{1'b0, 1'b0, 4'b1001, 4'b0000, 4'b0000};
    tbl[8]  = '{1'b0, 1'b0, 4'b1001, 4'b1000, 4'b1000};
    tbl[9]  = '{1'b0, 1'b0, 4'b1001, 4'b1000, 4'b1000};
    tbl[10] = '{1'b0, 1'b0, 4'b1001, 4'b1000, 4'b1000};
    tbl[11] = '{1'b0, 1'b0, 4'b1001, 4'b1000, 4'b1000};
    tbl[12] = '{1'b0, 1'b0, 4'b1001, 4'b0001, 4'b0001};
    tbl[13] = '{1'b0, 1'b0, 4'b1000, 4'b0001, 4'b0000};
    tbl[14] = '{1'b0, 1'b1, 4'b1000, 4'b1000, 4'b0000};
    tbl[15] = '{1'b1, 1'b0, 4'b1000, 4'b1000, 4'b0000};
    tbl[16] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000};
    tbl[17] = '{1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0001};
    req_data = {4'hD, 4'hC, 4'hB, 4'hA};
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; full = tbl[i].full; req = tbl[i].req;
      #2;
      exp_d = '0;
      if (!tbl[i].rst) begin
        for (int j = 0; j < N; j++) if (tbl[i].g[j]) exp_d = req_data[j*W +: W];
      end
      check($sformatf("vec%0d", i), {grant, ack, wr_en, data_in},
            {tbl[i].g, tbl[i].a, |tbl[i].a, exp_d});
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    // Single requester: ten back-to-back words, re-granted to itself at each burst cap.
    do_reset();
    for (int k = 0; k < 10; k++) pq[0].push_back(W'(k));
    cycle(1'b0, 1'b0);
    check("single_idle_grant", c_grant, '0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0);
      check("single_wr", {c_grant, c_wr, c_data}, {4'b0001, 1'b1, W'(k)});
    end
    cycle(1'b0, 1'b0);
    check("single_done", c_wr, 1'b0);

    // All contending: grants rotate 0,1,2,3 with four words each and no bubbles.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int s = 0; s < 8; s++) pq[i].push_back(W'(i*4 + s%4));
    cycle(1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 1'b0);
      check("rr_order", {c_grant, c_wr}, {4'(1 << (k / 4)), 1'b1});
    end
    drain();

    // Back-pressure: full stalls requester 2 mid-burst, count holds, then rotation to 0.
    do_reset();
    for (int k = 0; k < 6; k++) pq[2].push_back(W'(k));
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) pq[0].push_back(W'(8 + k));
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b1);
      check("bp_stall", {c_grant, c_wr}, {4'b0100, 1'b0});
      check("bp_cnt", dut.burst_cnt_q, 2);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0);
      check("bp_resume", {c_grant, c_wr}, {4'b0100, 1'b1});
    end
    cycle(1'b0, 1'b0);
    check("bp_rotate", c_grant, 4'b0001);
    drain();

    // Early drop: requester 1 leaves after one word, requester 3 takes over.
    do_reset();
    pq[1].push_back(4'h5);
    for (int k = 0; k < 3; k++) pq[3].push_back(W'(k));
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("drop_ack", c_ack, 4'b0010);
    cycle(1'b0, 1'b0);
    check("drop_grant", grant, 4'b1000);
    check("drop_ptr", dut.ptr_q, 2);
    drain();

    // Reset mid-burst.
    do_reset();
    for (int k = 0; k < 4; k++) pq[1].push_back(W'(k));
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("mid_first_word", {c_grant, c_wr}, {4'b0010, 1'b1});
    cycle(1'b1, 1'b0);
    check("mid_rst_wr", c_wr, 1'b0);
    check("mid_rst_grant", grant, '0);
    check("mid_rst_ptr", dut.ptr_q, '0);
    for (int i = 0; i < N; i++) pq[i].push_back(4'hF);
    cycle(1'b0, 1'b0);
    check("mid_regrant", grant, 4'b0001);
    drain();

    // End to end against a depth-8 FIFO whose reader starts late.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      nxt[i] = 0;
      for (int s = 0; s < 4; s++) pq[i].push_back(W'(i*4 + s));
    end
    got = 0; saw_stall = 0;
    for (int cyc = 0; cyc < 300 && got < 12; cyc++) begin
      if (fq.size() >= 8 && (pq[0].size() + pq[1].size() + pq[2].size()) > 0) saw_stall = 1;
      cycle(1'b0, fq.size() >= 8);
      if (cyc > 15 && fq.size() > 0 && $urandom_range(0, 2) == 0) begin
        d = fq.pop_front();
        id = int'(d[3:2]); seq = int'(d[1:0]);
        got++;
        if (id < 3) begin
          check("e2e_order", 64'(seq), 64'(nxt[id]));
          nxt[id]++;
        end else begin
          check("e2e_id", 64'(id), 64'd0);
        end
      end
      if (c_wr) begin
        if (fq.size() >= 8) check("e2e_overflow", 64'(fq.size()), 64'd7);
        fq.push_back(c_data);
      end
    end
    check("e2e_count", 64'(got), 64'd12);
    check("e2e_stall", 64'(saw_stall), 64'd1);
    check("e2e_left", 64'(fq.size()), 64'd0);

    // Random traffic, back-pressure and occasional reset against the model.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++)
        if (pq[i].size() < 6 && $urandom_range(0, 3) == 0) pq[i].push_back(W'($urandom));
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0);
    end

    // MAX_BURST = 1: grant moves after every accepted word, holds under full.
    @(negedge clk);
    rst1 = 1'b0;
    e = 0;
    for (int k = 0; k < 9; k++) begin
      full1 = (k == 5);
      #2;
      if (k == 0) begin
        check("mb1_idle", grant1, '0);
      end else begin
        check("mb1_grant", grant1, 64'd1 << e);
        check("mb1_wr", {wr_en1, data_in1}, {!full1, W'(e + 1)});
        if (!full1) e = (e + 1) % N;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the asynchronous FIFO (`asyn_fifo`) among several producers in the write-clock domain. It grants one requester at a time, forwards that requester's data as `wr_en`/`data_in` to the FIFO, honours `full` back-pressure, and caps each grant at a fixed burst length so no producer can starve the others.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DATASIZE`, 4: data word width, matches the FIFO `DATASIZE`.
- `MAX_BURST`, 4: maximum words accepted per grant, at least 1.

- `clk`  in  1  write-side clock, the same clock as the FIFO `wr_clk`.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request; held high while the requester has a word on its data lane.
- `req_data`  in  NREQ*DATASIZE  data lanes; lane i is `req_data[i*DATASIZE +: DATASIZE]`.
- `ack`  out  NREQ  one-hot, combinational; the word on lane i is consumed this cycle.
- `grant`  out  NREQ  one-hot or zero, registered; the current owner of the write port.
- `full`  in  1  FIFO full flag.
- `wr_en`  out  1  FIFO write enable, combinational.
- `data_in`  out  DATASIZE  FIFO write data, combinational.

## Operation
- **States**
  - IDLE: `grant` = 0.
  - BUSY: exactly one `grant` bit is set.
- **Registers**
  - `grant`.
  - `ptr`: highest-priority index, width clog2(NREQ).
  - `burst_cnt`: width clog2(MAX_BURST+1).
- **Accept rule**, with g as the granted index:
  - `ack[g] = grant[g] & req[g] & ~full & ~rst`.
  - `wr_en = |ack`.
  - `data_in` = lane g while in BUSY, otherwise 0.
- **Round-robin pick from `req`**: scan indices `ptr`, `ptr`+1, … modulo NREQ; the first index with `req` high wins.
- **IDLE**: if any `req` bit is high, at the next edge set `grant` to the pick, clear `burst_cnt`, and go to BUSY. Otherwise stay in IDLE.
- **BUSY**: each accepted word increments `burst_cnt`.
- **Release condition**, evaluated each cycle:
  - (a) `req[g]` is low, or
  - (b) this cycle's accept makes `burst_cnt` equal MAX_BURST.
- **On release, at the next edge**:
  - Set `ptr` to (g+1) mod NREQ.
  - Re-pick immediately from the current `req` with `ptr` = g+1. Requester g competes at the lowest priority, so it wins again only if it is the sole requester.
  - If the pick is non-empty, stay in BUSY with the new grant and `burst_cnt` = 0. Otherwise go to IDLE.
  - There is no bubble cycle between grants.
- **Full**: while `full` is high there is no accept and `burst_cnt` holds. The grant holds indefinitely; there is no timeout. Release by (a) still applies.
- **Requester contract**:
  - `req_data[i]` is stable while `req[i]` is high and `ack[i]` is low.
  - After `ack[i]` the requester may present the next word or drop `req[i]`.
  - A requester never drops `req` in a cycle where its `ack` is pending.

## Timing
- **Reset**: `grant` = 0, `ptr` = 0, `burst_cnt` = 0, state IDLE. `ack`, `wr_en` and `data_in` are 0 during any cycle in which `rst` is high.
- **Reset mid-burst**: the write is suppressed in the reset cycle, `grant` is 0 after the edge, and the burst is abandoned. No partial state survives.
- **Latency**:
  - `req` rising in IDLE gives `grant` after 1 edge; the first `wr_en` comes in that same following cycle if `full` is low.
  - Sustained throughput is 1 word/clk across grant changes.
- **Simultaneous events**: a release by (a) and by (b) in the same cycle is a single release. `full` rising in the same cycle as the MAX_BURST-th candidate word blocks it, and no release occurs.
- **Wrap-around**: the `ptr` update from g = NREQ-1 yields 0, and the scan wraps modulo NREQ.
- **Burst boundary**: with MAX_BURST = 1, release happens after every accepted word.

## Test plan
- **Single requester burst**: reset, then `req` = 4'b0001 for 10 cycles with `full` = 0.
  - `grant` = 0001 one cycle later.
  - `wr_en` high for 10 consecutive cycles, with the grant re-picked for 0 after each 4 words.
  - `data_in` follows lane 0.
- **All requesters contending**: `req` = 4'b1111 held, `full` = 0.
  - Grant order 0,1,2,3,0…, with 4 words each.
  - 16 consecutive `wr_en` cycles with no gap.
- **Back-pressure**: requester 2 granted after 2 words, then `full` forced high for 5 cycles.
  - `wr_en` = 0, `grant` stays 0100, `burst_cnt` stays 2.
  - After `full` drops, 2 more words are accepted, then the grant rotates.
- **Early drop**: requester 1 drops `req` after 1 accepted word while `req[3]` is high.
  - The next edge gives `grant` = 1000 and `ptr` = 2.
- **Reset mid-burst**: assert `rst` for 1 cycle while `grant` = 0010 with 1 word accepted.
  - `wr_en` = 0 in the reset cycle; `grant` = 0 and `ptr` = 0 after it.
  - With `req` = 1111, the next grant is 0001.
- **End to end with the FIFO**: connect to `asyn_fifo` (DEPTH = 8) and write 12 words from 3 requesters.
  - `full` stalls the writes.
  - The read side sees every word exactly once, in per-requester order.
